// File: rtl/simple_adapter_pkg.sv
// -----------------------------------------------------------------------------
// simple_adapter_pkg
//   Definitions shared by the n->2n packer and the 2n->n unpacker.
//   - adapter_state_e : FSM state encoding (IDLE / HI / LO)
//   - UPPER_FIRST     : word ordering on the narrow side; the upper half of a
//                       wide word travels first.
// -----------------------------------------------------------------------------
package simple_adapter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HI   = 2'd1,
        ST_LO   = 2'd2
    } adapter_state_e;

    localparam bit UPPER_FIRST = 1'b1;

endpackage

// File: rtl/simple_unpacker.sv
// -----------------------------------------------------------------------------
// simple_unpacker
//   Splits each 2n-bit input word into two n-bit output words, upper half
//   first, with valid/ready handshakes on both sides. Frame boundaries ride on
//   din_last / dout_last; dout_last marks the second (final) half of a word.
//
// Optional build macro: SIMPLE_UNPACKER_HALF_LAST_EN
//   Adds input din_half. A word with din_last=1 and din_half=1 emits only its
//   upper half, flagged dout_last=1 (odd-length frames).
//
// Ports
//   clk        in   clock, all logic on rising edge
//   rstn       in   synchronous reset, active-low
//   din_vld    in   input word valid
//   din_rdy    out  input accepted this cycle (combinational)
//   din_last   in   input word is last of frame
//   din_half   in   (macro only) emit upper half only
//   din        in   {first_word, second_word}, 2*WIDTH_DIN bits
//   dout_vld   out  output word valid (registered)
//   dout_rdy   in   sink accepts output this cycle
//   dout_last  out  output word is last of frame (registered)
//   dout       out  output word (registered)
//
// state | meaning
// IDLE  | output register empty
// HI    | dout shows the first (upper) half
// LO    | dout shows the second (lower) half
// -----------------------------------------------------------------------------
module simple_unpacker
    import simple_adapter_pkg::*;
#(
    parameter int WIDTH_DIN = 8
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   din_vld,
    output logic                   din_rdy,
    input  logic                   din_last,
`ifdef SIMPLE_UNPACKER_HALF_LAST_EN
    input  logic                   din_half,
`endif
    input  logic [2*WIDTH_DIN-1:0] din,
    output logic                   dout_vld,
    input  logic                   dout_rdy,
    output logic                   dout_last,
    output logic [WIDTH_DIN-1:0]   dout
);

    adapter_state_e       state_q, state_d;
    logic [WIDTH_DIN-1:0] dout_q, dout_d;
    logic                 dout_vld_q, dout_vld_d;
    logic                 dout_last_q, dout_last_d;
    logic [WIDTH_DIN-1:0] lo_hold_q, lo_hold_d;
    logic                 last_hold_q, last_hold_d;
`ifdef SIMPLE_UNPACKER_HALF_LAST_EN
    logic                 half_hold_q, half_hold_d;
`endif

    logic [WIDTH_DIN-1:0] first_word;
    logic [WIDTH_DIN-1:0] second_word;
    logic                 word_done;
    logic                 in_xfer;
    logic                 half_only;

    assign first_word  = UPPER_FIRST ? din[2*WIDTH_DIN-1:WIDTH_DIN] : din[WIDTH_DIN-1:0];
    assign second_word = UPPER_FIRST ? din[WIDTH_DIN-1:0] : din[2*WIDTH_DIN-1:WIDTH_DIN];

`ifdef SIMPLE_UNPACKER_HALF_LAST_EN
    assign half_only = din_last && din_half;
`else
    assign half_only = 1'b0;
`endif

    // word_done: the output register is empty, or its final word for the
    // current input leaves this cycle, so a new input word may be loaded.
    always_comb begin
        word_done = 1'b0;
        case (state_q)
            ST_IDLE: word_done = 1'b1;
            ST_LO:   word_done = dout_rdy;
`ifdef SIMPLE_UNPACKER_HALF_LAST_EN
            ST_HI:   word_done = dout_rdy && half_hold_q;
`endif
            default: word_done = 1'b0;
        endcase
    end

    assign din_rdy = word_done;
    assign in_xfer = din_vld && word_done;

    always_comb begin
        state_d     = state_q;
        dout_d      = dout_q;
        dout_vld_d  = dout_vld_q;
        dout_last_d = dout_last_q;
        lo_hold_d   = lo_hold_q;
        last_hold_d = last_hold_q;
`ifdef SIMPLE_UNPACKER_HALF_LAST_EN
        half_hold_d = half_hold_q;
`endif

        if (word_done) begin
            if (in_xfer) begin
                state_d     = ST_HI;
                dout_d      = first_word;
                lo_hold_d   = second_word;
                last_hold_d = din_last;
                dout_vld_d  = 1'b1;
                dout_last_d = half_only;
`ifdef SIMPLE_UNPACKER_HALF_LAST_EN
                half_hold_d = half_only;
`endif
            end else begin
                state_d     = ST_IDLE;
                dout_vld_d  = 1'b0;
                dout_last_d = 1'b0;
            end
        end else if (state_q == ST_HI && dout_rdy) begin
            state_d     = ST_LO;
            dout_d      = lo_hold_q;
            dout_last_d = last_hold_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            dout_q      <= '0;
            dout_vld_q  <= 1'b0;
            dout_last_q <= 1'b0;
            lo_hold_q   <= '0;
            last_hold_q <= 1'b0;
`ifdef SIMPLE_UNPACKER_HALF_LAST_EN
            half_hold_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            dout_q      <= dout_d;
            dout_vld_q  <= dout_vld_d;
            dout_last_q <= dout_last_d;
            lo_hold_q   <= lo_hold_d;
            last_hold_q <= last_hold_d;
`ifdef SIMPLE_UNPACKER_HALF_LAST_EN
            half_hold_q <= half_hold_d;
`endif
        end
    end

    assign dout      = dout_q;
    assign dout_vld  = dout_vld_q;
    assign dout_last = dout_last_q;

endmodule
